// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID register bank.
package instruction_fetch_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_ifid.sv
// IF/ID pipeline register: load captures a fetch, clear injects a NOP bubble,
// drop only invalidates (contents kept), otherwise everything holds.
module ifid_register
    import instruction_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              drop,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] pc_plus4_in,
    output logic [WORD_W-1:0] ifid_instruction,
    output logic [WORD_W-1:0] ifid_pc_plus4,
    output logic              ifid_valid
);

    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
    logic              valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (load) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end else if (clear) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (drop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= NOP;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign ifid_instruction = instr_q;
    assign ifid_pc_plus4    = pc_plus4_q;
    assign ifid_valid       = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, START/RUN/HALT control and fault/count tracking; one-cycle
// address-to-IF/ID latency, stall holds everything, branch redirects with a bubble.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] instruction_address,
    input  logic [31:0] instruction,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam logic [WORD_W-1:0] PC_LIMIT = WORD_W'(IMEM_WORDS * 4);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] count_q, count_d;
    logic              ifid_load, ifid_clear, ifid_drop;
    logic [WORD_W-1:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        count_d    = count_q;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        ifid_drop  = 1'b0;
        case (state_q)
            START: state_d = RUN;
            RUN: begin
                if (branch_taken) begin
                    if (branch_target[1:0] != 2'b00) begin
                        state_d   = HALT;
                        fault_d   = 1'b1;
                        ifid_drop = 1'b1;
                    end else begin
                        pc_d       = branch_target;
                        ifid_clear = 1'b1;
                    end
                // Fault check precedes stall so a bad PC halts even while decode holds.
                end else if (pc_q >= PC_LIMIT || pc_q[1:0] != 2'b00) begin
                    state_d   = HALT;
                    fault_d   = 1'b1;
                    ifid_drop = 1'b1;
                end else if (!stall) begin
                    pc_d      = pc_plus4;
                    count_d   = count_q + 32'd1;
                    ifid_load = 1'b1;
                end
            end
            HALT: ;
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= START;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    ifid_register u_ifid (
        .clk              (clk),
        .rst              (rst),
        .load             (ifid_load),
        .clear            (ifid_clear),
        .drop             (ifid_drop),
        .instr_in         (instruction),
        .pc_plus4_in      (pc_plus4),
        .ifid_instruction (ifid_instruction),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid)
    );

    assign instruction_address = pc_q;
    assign fetch_fault         = fault_q;
    assign fetch_count         = count_q;

endmodule
